// File: rtl/hart_arb_pkg.sv
// hart_arb_pkg: shared types, mode constants and select-width helper for hart arbiters
package hart_arb_pkg;
    typedef enum logic {RUN, HANDOFF} arb_state_t;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/hart_rr_picker.sv
// hart_rr_picker: combinational next-hart picker; req = candidates, start = first index
// scanned in round-robin mode (ignored in fixed mode), mode = 1 for lowest-index-wins,
// idx/valid = chosen hart and whether any request exists
module hart_rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         valid
);
    always_comb begin
        int p;
        p = 0;
        idx = '0;
        valid = |req;
        // Scan from the farthest offset down so the nearest requester wins last.
        for (int i = N - 1; i >= 0; i--) begin
            p = (mode ? 0 : int'(start)) + i;
            if (p >= N) p -= N;
            if (|(req & (N'(1) << p))) idx = W'(p);
        end
    end
endmodule

// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter: time-multiplexes the shared memory/MMU port between harts.
// CLK/RST clock and async reset; i_req pending work; i_yield_ok safe switch point;
// i_mode_is_cpu/i_next_mode_is_mc controller mode; i_busy shared port busy;
// o_sel owner; o_grant one-hot owner; o_core_busy per-hart stall; o_switch hand-off
// bubble; o_qcnt owner's safe-point count.
module hart_mem_arbiter
    import hart_arb_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int QUANTUM = 4,
    parameter int MODE    = 0,
    localparam int SELW   = sel_width(N_HARTS),
    localparam int QW     = $clog2(QUANTUM + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_HARTS-1:0]  i_req,
    input  logic [N_HARTS-1:0]  i_yield_ok,
    input  logic                i_mode_is_cpu,
    input  logic                i_next_mode_is_mc,
    input  logic                i_busy,
    output logic [SELW-1:0]     o_sel,
    output logic [N_HARTS-1:0]  o_grant,
    output logic [N_HARTS-1:0]  o_core_busy,
    output logic                o_switch,
    output logic [QW-1:0]       o_qcnt
);
    arb_state_t         state, state_n;
    logic [SELW-1:0]    sel_n, start, cand;
    logic [QW-1:0]      qcnt_n, qcnt_inc;
    logic [N_HARTS-1:0] mask, others;
    logic               safe, own_req, c_valid, q_hit, preempt;

    assign mask     = N_HARTS'(1) << o_sel;
    assign others   = i_req & ~mask;
    assign own_req  = |(i_req & mask);
    assign safe     = i_mode_is_cpu & ~i_next_mode_is_mc & ~i_busy & |(i_yield_ok & mask);
    assign start    = (o_sel == SELW'(N_HARTS - 1)) ? '0 : o_sel + 1'b1;
    assign qcnt_inc = (o_qcnt == QW'(QUANTUM)) ? o_qcnt : o_qcnt + 1'b1;
    assign q_hit    = int'(o_qcnt) + 1 >= QUANTUM;
    assign preempt  = (MODE == ARB_FIXED) && (cand < o_sel);

    hart_rr_picker #(.N(N_HARTS), .W(SELW)) u_pick (
        .req   (others),
        .start (start),
        .mode  (MODE == ARB_FIXED),
        .idx   (cand),
        .valid (c_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= RUN;
            o_sel  <= '0;
            o_qcnt <= '0;
        end else begin
            state  <= state_n;
            o_sel  <= sel_n;
            o_qcnt <= qcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = o_sel;
        qcnt_n  = o_qcnt;
        if (state == HANDOFF) begin
            state_n = RUN;
        end else if (safe) begin
            if (c_valid && (!own_req || q_hit || preempt)) begin
                state_n = HANDOFF;
                sel_n   = cand;
                qcnt_n  = '0;
            end else begin
                qcnt_n = qcnt_inc;
            end
        end
    end

    assign o_grant     = (state == RUN) ? mask : '0;
    assign o_core_busy = (state == RUN) ? (~mask | {N_HARTS{i_busy}}) : '1;
    assign o_switch    = state == HANDOFF;
endmodule
